// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - word-addressed data RAM with a posted one-entry write buffer
// Loads see buffered stores through byte-lane forwarding; out-of-range accesses raise a sticky flag.
module data_ram_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_ram_en,
  input  logic [3:0]  data_ram_w_en_4bit,
  input  logic [31:0] data_ram_addr,
  input  logic [31:0] data_ram_w_data,
  output logic [31:0] data_ram_r_data,
  output logic        data_ram_r_valid,
  output logic        addr_err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           r_mem [DEPTH];
  logic                  r_wb_valid;
  logic [DEPTH_LOG2-1:0] r_wb_idx;
  logic [3:0]            r_wb_be;
  logic [31:0]           r_wb_data;
  logic [31:0]           r_rdata;
  logic                  r_rvalid;
  logic                  r_addr_err;
  logic [15:0]           r_rd_cnt;
  logic [15:0]           r_wr_cnt;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_oor;
  logic                  w_is_write;
  logic [31:0]           w_fwd_data;
  logic                  w_unused_addr_lo;

  assign w_idx            = data_ram_addr[DEPTH_LOG2+1:2];
  assign w_oor            = |data_ram_addr[31:DEPTH_LOG2+2];
  assign w_is_write       = |data_ram_w_en_4bit;
  assign w_unused_addr_lo = ^data_ram_addr[1:0];

  // The buffer is sampled before the edge that commits it, so a load in the
  // same cycle as the commit still sees the stored bytes.
  always_comb begin
    w_fwd_data = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (r_wb_valid && (r_wb_idx == w_idx) && r_wb_be[i]) begin
        w_fwd_data[8*i +: 8] = r_wb_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_wb_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wb_be[i]) begin
          r_mem[r_wb_idx][8*i +: 8] <= r_wb_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wb_valid <= 1'b0;
      r_wb_idx   <= '0;
      r_wb_be    <= 4'b0;
      r_wb_data  <= 32'h0;
      r_rdata    <= 32'h0;
      r_rvalid   <= 1'b0;
      r_addr_err <= 1'b0;
      r_rd_cnt   <= 16'h0;
      r_wr_cnt   <= 16'h0;
    end else begin
      r_wb_valid <= 1'b0;
      r_rvalid   <= 1'b0;
      if (data_ram_en) begin
        if (w_is_write) begin
          if (w_oor) begin
            r_addr_err <= 1'b1;
          end else begin
            r_wb_valid <= 1'b1;
            r_wb_idx   <= w_idx;
            r_wb_be    <= data_ram_w_en_4bit;
            r_wb_data  <= data_ram_w_data;
            r_wr_cnt   <= r_wr_cnt + 16'h1;
          end
        end else begin
          r_rvalid <= 1'b1;
          if (w_oor) begin
            r_rdata    <= 32'h0;
            r_addr_err <= 1'b1;
          end else begin
            r_rdata  <= w_fwd_data;
            r_rd_cnt <= r_rd_cnt + 16'h1;
          end
        end
      end
    end
  end

  assign data_ram_r_data  = r_rdata;
  assign data_ram_r_valid = r_rvalid;
  assign addr_err         = r_addr_err;
  assign rd_cnt           = r_rd_cnt;
  assign wr_cnt           = r_wr_cnt;

endmodule
